clint_mc: RTL and testbench
===========================

Name: clint_mc

Overview:
- Multi-channel successor to the core-local interrupt controller; sits between ID/EX, csr_reg and ctrl.
- Arbitrates NUM_INT level-sensitive async sources with per-source enables, fixed priority and per-source cause codes.
- Also arbitrates sync exceptions (ecall/ebreak) and mret.
- Saves and restores MIE through MPIE, runs the CSR write sequence, then redirects EX.

Parameters:
- NUM_INT, 4, number of async interrupt sources (1..16); index 0 has highest priority.
- CAUSE_BASE, 16, mcause code of source 0; source i uses CAUSE_BASE+i.
- XLEN, 32, data/address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- int_req_i  in  NUM_INT  level interrupt requests
- int_en_i  in  NUM_INT  per-source enable (mie slice)
- global_int_en_i  in  1  mstatus.MIE
- inst_i  in  32  ID instruction
- inst_addr_i  in  XLEN  ID instruction address
- jump_flag_i  in  1  EX jump taken
- jump_addr_i  in  XLEN  EX jump target
- div_started_i  in  1  divider busy
- csr_mtvec  in  XLEN  mtvec value
- csr_mepc  in  XLEN  mepc value
- csr_mstatus  in  XLEN  mstatus value
- hold_flag_o  out  1  pipeline hold
- we_o  out  1  CSR write enable
- waddr_o  out  XLEN  CSR write address
- data_o  out  XLEN  CSR write data
- int_assert_o  out  1  redirect pulse to EX
- int_addr_o  out  XLEN  redirect target
- int_ack_o  out  NUM_INT  one-hot acknowledge pulse to the serviced source

Behaviour:
- Reset: clk-synchronous, active-high rst. The FSM goes to IDLE. All registered outputs are 0, and so are the internal epc/cause/index registers. Reset mid-sequence aborts with no further CSR writes.
- Pending vector: pend = int_req_i & int_en_i. An async request is valid when pend != 0 and global_int_en_i = 1. The winner is the lowest set index.
- Decision is made in IDLE only. Priority order:
  - inst_i = ECALL/EBREAK with div_started_i = 0 → SYNC. If div_started_i = 1, stay IDLE.
  - Else a valid async request → ASYNC.
  - Else inst_i = MRET → MRET.
- Latched on the acceptance edge:
  - SYNC: epc = jump_flag_i ? jump_addr_i-4 : inst_addr_i. Cause = 11 for ecall, 3 for ebreak.
  - ASYNC: epc = jump_flag_i ? jump_addr_i : (div_started_i ? inst_addr_i-4 : inst_addr_i). Cause = {1'b1, CAUSE_BASE+idx}, with idx also latched.
- FSM states: IDLE → MEPC → MSTATUS → MCAUSE → IDLE for trap entry; IDLE → MRET → IDLE for return. Each non-IDLE state lasts exactly one cycle.
- Outputs are registered one cycle after each state:
  - MEPC: we_o=1, waddr_o=0x341, data_o=epc.
  - MSTATUS: we_o=1, waddr_o=0x300, data_o = mstatus with bit7 (MPIE) = bit3 and bit3 (MIE) = 0.
  - MCAUSE: we_o=1, waddr_o=0x342, data_o=cause. In the same cycle int_assert_o=1, int_addr_o=trap target, and int_ack_o[idx]=1 (ASYNC only).
  - MRET: we_o=1, waddr_o=0x300, data_o = mstatus with bit3 = bit7 and bit7 = 1. In the same cycle int_assert_o=1, int_addr_o=csr_mepc.
  - Otherwise we_o, waddr_o, data_o, int_assert_o, int_addr_o and int_ack_o are all 0.
- Trap target: {csr_mtvec[XLEN-1:2], 2'b00}, unless modified by the optional feature.
- hold_flag_o is combinational: 1 when the FSM is not IDLE, or when IDLE and a SYNC/ASYNC/MRET condition is present this cycle.
- Trap entry latency: decision at edge E0; MEPC write after E1; MSTATUS write after E2; MCAUSE write plus assert after E3. The MRET assert appears after E1.
- Request removed after acceptance: the sequence completes with the latched cause and idx.
- Requests arriving during a sequence are ignored until IDLE; they are level-sensitive, so they are re-evaluated then.
- Arithmetic: subtraction of 4 wraps modulo 2^XLEN.

Optional Feature:
- Macro: CLINT_MC_VECTORED_EN.
- Defined: if csr_mtvec[1:0] = 2'b01 and the trap is ASYNC, int_addr_o = {mtvec[XLEN-1:2], 2'b00} + 4*(CAUSE_BASE+idx). SYNC traps still use the base address.
- Undefined: mtvec[1:0] is ignored and all traps go to the base address.

Test Plan:
- Ecall: inst_i=ECALL at 0x100, mtvec=0x200, mstatus=0x8 → writes 0x341←0x100, 0x300←0x80, 0x342←11; int_assert_o with int_addr_o=0x200; hold_flag_o high for 4 cycles.
- Priority: int_req_i=4'b1010, int_en_i=4'hF, MIE=1 → cause 0x80000011 (idx1), int_ack_o=4'b0010. With int_en_i=4'b1000 → cause 0x80000013.
- Masking: int_req_i=4'b0001 with global_int_en_i=0, or with int_en_i[0]=0 → no writes, hold_flag_o=0.
- Sync beats async, divider, jump:
  - ECALL together with int_req_i[0] → cause 11.
  - div_started_i=1 with ECALL → stays IDLE.
  - Async with jump_flag_i=1, jump_addr_i=0x400 → mepc=0x400.
- MRET: mstatus=0x80, mepc=0x104 → write 0x300←0x88; int_assert_o with int_addr_o=0x104 one cycle after acceptance.
- Vectored and reset:
  - CLINT_MC_VECTORED_EN defined, mtvec=0x201, idx2 → int_addr_o = 0x200 + 4*18 = 0x248.
  - rst asserted during MSTATUS → no MCAUSE write, all outputs 0 next cycle.

Source files
------------

// File: rtl/clint_mc.sv
// Multi-channel core-local interrupt controller: arbitrates prioritised async sources,
// ecall/ebreak and mret, and runs the CSR trap entry/return sequence.
// Define CLINT_MC_VECTORED_EN to honour vectored mtvec mode for async traps.
module clint_mc #(
    parameter int NUM_INT    = 4,
    parameter int CAUSE_BASE = 16,
    parameter int XLEN       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_INT-1:0] int_req_i,
    input  logic [NUM_INT-1:0] int_en_i,
    input  logic               global_int_en_i,
    input  logic [31:0]        inst_i,
    input  logic [XLEN-1:0]    inst_addr_i,
    input  logic               jump_flag_i,
    input  logic [XLEN-1:0]    jump_addr_i,
    input  logic               div_started_i,
    input  logic [XLEN-1:0]    csr_mtvec,
    input  logic [XLEN-1:0]    csr_mepc,
    input  logic [XLEN-1:0]    csr_mstatus,
    output logic               hold_flag_o,
    output logic               we_o,
    output logic [XLEN-1:0]    waddr_o,
    output logic [XLEN-1:0]    data_o,
    output logic               int_assert_o,
    output logic [XLEN-1:0]    int_addr_o,
    output logic [NUM_INT-1:0] int_ack_o
);

    localparam int IDX_W = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEPC,
        S_MSTATUS,
        S_MCAUSE,
        S_MRET
    } state_t;

    state_t             r_state;
    logic [XLEN-1:0]    r_epc;
    logic [XLEN-1:0]    r_cause;
    logic [IDX_W-1:0]   r_idx;
    logic               r_async;

    logic               r_we;
    logic [XLEN-1:0]    r_waddr;
    logic [XLEN-1:0]    r_data;
    logic               r_assert;
    logic [XLEN-1:0]    r_addr;
    logic [NUM_INT-1:0] r_ack;

    logic [NUM_INT-1:0] w_pend;
    logic               w_async_valid;
    logic               w_is_sync_inst;
    logic               w_sync_go;
    logic               w_async_go;
    logic               w_mret_go;
    logic [IDX_W-1:0]   w_win_idx;
    logic [XLEN-1:0]    w_mstatus_trap;
    logic [XLEN-1:0]    w_mstatus_ret;
    logic [XLEN-1:0]    w_trap_base;
    logic [XLEN-1:0]    w_trap_target;
    logic [NUM_INT-1:0] w_ack_onehot;

    assign w_pend         = int_req_i & int_en_i;
    assign w_async_valid  = (w_pend != '0) && global_int_en_i;
    assign w_is_sync_inst = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);

    // A sync instruction blocks async/mret arbitration even while the divider holds it off.
    assign w_sync_go  = w_is_sync_inst && !div_started_i;
    assign w_async_go = !w_is_sync_inst && w_async_valid;
    assign w_mret_go  = !w_is_sync_inst && !w_async_valid && (inst_i == INST_MRET);

    assign hold_flag_o = (r_state != S_IDLE) || w_sync_go || w_async_go || w_mret_go;

    always_comb begin
        w_win_idx = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_win_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_mstatus_trap    = csr_mstatus;
        w_mstatus_trap[7] = csr_mstatus[3];
        w_mstatus_trap[3] = 1'b0;
        w_mstatus_ret     = csr_mstatus;
        w_mstatus_ret[3]  = csr_mstatus[7];
        w_mstatus_ret[7]  = 1'b1;
    end

    assign w_trap_base = {csr_mtvec[XLEN-1:2], 2'b00};

`ifdef CLINT_MC_VECTORED_EN
    assign w_trap_target = (r_async && (csr_mtvec[1:0] == 2'b01))
                         ? w_trap_base + ((XLEN'(CAUSE_BASE) + XLEN'(r_idx)) << 2)
                         : w_trap_base;
`else
    logic w_unused_mtvec_mode;
    assign w_unused_mtvec_mode = ^csr_mtvec[1:0];
    assign w_trap_target       = w_trap_base;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INT; gi++) begin : g_ack
            assign w_ack_onehot[gi] = r_async && (r_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_epc    <= '0;
            r_cause  <= '0;
            r_idx    <= '0;
            r_async  <= 1'b0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_data   <= '0;
            r_assert <= 1'b0;
            r_addr   <= '0;
            r_ack    <= '0;
        end else begin
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_data   <= '0;
            r_assert <= 1'b0;
            r_addr   <= '0;
            r_ack    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_sync_go) begin
                        r_epc   <= jump_flag_i ? (jump_addr_i - XLEN'(4)) : inst_addr_i;
                        r_cause <= (inst_i == INST_ECALL) ? XLEN'(11) : XLEN'(3);
                        r_async <= 1'b0;
                        r_state <= S_MEPC;
                    end else if (w_async_go) begin
                        r_epc   <= jump_flag_i ? jump_addr_i
                                 : (div_started_i ? (inst_addr_i - XLEN'(4)) : inst_addr_i);
                        r_cause <= {1'b1, (XLEN-1)'(CAUSE_BASE) + (XLEN-1)'(w_win_idx)};
                        r_idx   <= w_win_idx;
                        r_async <= 1'b1;
                        r_state <= S_MEPC;
                    end else if (w_mret_go) begin
                        r_state <= S_MRET;
                    end
                end
                S_MEPC: begin
                    r_we    <= 1'b1;
                    r_waddr <= XLEN'(32'h341);
                    r_data  <= r_epc;
                    r_state <= S_MSTATUS;
                end
                S_MSTATUS: begin
                    r_we    <= 1'b1;
                    r_waddr <= XLEN'(32'h300);
                    r_data  <= w_mstatus_trap;
                    r_state <= S_MCAUSE;
                end
                S_MCAUSE: begin
                    r_we     <= 1'b1;
                    r_waddr  <= XLEN'(32'h342);
                    r_data   <= r_cause;
                    r_assert <= 1'b1;
                    r_addr   <= w_trap_target;
                    r_ack    <= w_ack_onehot;
                    r_state  <= S_IDLE;
                end
                S_MRET: begin
                    r_we     <= 1'b1;
                    r_waddr  <= XLEN'(32'h300);
                    r_data   <= w_mstatus_ret;
                    r_assert <= 1'b1;
                    r_addr   <= csr_mepc;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign we_o         = r_we;
    assign waddr_o      = r_waddr;
    assign data_o       = r_data;
    assign int_assert_o = r_assert;
    assign int_addr_o   = r_addr;
    assign int_ack_o    = r_ack;

endmodule

// File: tb/tb_clint_mc.sv
// Randomized bench for clint_mc against a transaction-level model of the trap/return
// CSR sequences; follows CLINT_MC_VECTORED_EN if it is defined for the build.
module tb_clint_mc;

    localparam int NUM_INT    = 4;
    localparam int CAUSE_BASE = 16;
    localparam int XLEN       = 32;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_INT-1:0] int_req_i;
    logic [NUM_INT-1:0] int_en_i;
    logic               global_int_en_i;
    logic [31:0]        inst_i;
    logic [XLEN-1:0]    inst_addr_i;
    logic               jump_flag_i;
    logic [XLEN-1:0]    jump_addr_i;
    logic               div_started_i;
    logic [XLEN-1:0]    csr_mtvec;
    logic [XLEN-1:0]    csr_mepc;
    logic [XLEN-1:0]    csr_mstatus;
    logic               hold_flag_o;
    logic               we_o;
    logic [XLEN-1:0]    waddr_o;
    logic [XLEN-1:0]    data_o;
    logic               int_assert_o;
    logic [XLEN-1:0]    int_addr_o;
    logic [NUM_INT-1:0] int_ack_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clint_mc #(.NUM_INT(NUM_INT), .CAUSE_BASE(CAUSE_BASE), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .int_req_i(int_req_i), .int_en_i(int_en_i), .global_int_en_i(global_int_en_i),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .div_started_i(div_started_i),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus),
        .hold_flag_o(hold_flag_o), .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
        .int_assert_o(int_assert_o), .int_addr_o(int_addr_o), .int_ack_o(int_ack_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_we, input logic [31:0] e_wa,
                              input logic [31:0] e_d, input logic e_as, input logic [31:0] e_ad,
                              input logic [3:0] e_ack, input logic e_hold);
        check({tag, ".we"},     32'(we_o),         32'(e_we));
        check({tag, ".waddr"},  waddr_o,           e_wa);
        check({tag, ".data"},   data_o,            e_d);
        check({tag, ".assert"}, 32'(int_assert_o), 32'(e_as));
        check({tag, ".addr"},   int_addr_o,        e_ad);
        check({tag, ".ack"},    32'(int_ack_o),    32'(e_ack));
        check({tag, ".hold"},   32'(hold_flag_o),  32'(e_hold));
    endtask

    task automatic clear_triggers();
        inst_i        = NOP;
        int_req_i     = '0;
        jump_flag_i   = 1'b0;
        div_started_i = 1'b0;
    endtask

    // kind: 0 nothing, 1 sync trap, 2 async trap, 3 mret
    task automatic do_trans(input int id, input logic [31:0] inst, input logic [3:0] req,
                            input logic [3:0] en, input logic gie, input logic jf,
                            input logic [31:0] ja, input logic div, input logic [31:0] ia,
                            input logic [31:0] mtvec, input logic [31:0] ms,
                            input logic [31:0] mepc);
        logic [3:0]  pend;
        int          kind;
        int          idx;
        logic [31:0] epc, cause, target, ms_trap, ms_ret;
        logic [3:0]  ack;
        string       tag;

        pend = req & en;
        idx  = -1;
        for (int i = 0; i < NUM_INT; i++)
            if (pend[i] && idx < 0) idx = i;
        if (inst == ECALL || inst == EBREAK) kind = div ? 0 : 1;
        else if (pend != 0 && gie)           kind = 2;
        else if (inst == MRET)               kind = 3;
        else                                 kind = 0;

        epc = 0; cause = 0; ack = 0;
        target = mtvec & ~32'h3;
        if (kind == 1) begin
            epc   = jf ? ja - 32'd4 : ia;
            cause = (inst == ECALL) ? 32'd11 : 32'd3;
        end else if (kind == 2) begin
            epc   = jf ? ja : (div ? ia - 32'd4 : ia);
            cause = 32'h8000_0000 + 32'(CAUSE_BASE + idx);
            ack   = 4'(1 << idx);
`ifdef CLINT_MC_VECTORED_EN
            if (mtvec[1:0] == 2'b01) target = target + 32'(4 * (CAUSE_BASE + idx));
`endif
        end
        ms_trap = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0);
        ms_ret  = (ms & ~32'h08) | (ms[7] ? 32'h08 : 32'h0) | 32'h80;

        $display("txn %0d inst=%08h req=%b en=%b gie=%0d jf=%0d div=%0d kind=%0d idx=%0d",
                 id, inst, req, en, gie, jf, div, kind, idx);

        @(negedge clk);
        inst_i = inst; int_req_i = req; int_en_i = en; global_int_en_i = gie;
        jump_flag_i = jf; jump_addr_i = ja; div_started_i = div; inst_addr_i = ia;
        csr_mtvec = mtvec; csr_mstatus = ms; csr_mepc = mepc;
        #1;
        $sformat(tag, "t%0d.decide", id);
        check({tag, ".hold"}, 32'(hold_flag_o), 32'(kind != 0));

        @(posedge clk);
        @(negedge clk);
        clear_triggers();
        #1;
        $sformat(tag, "t%0d.k0", id);
        check_outs(tag, 0, 0, 0, 0, 0, 0, kind != 0);

        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            $sformat(tag, "t%0d.k%0d", id, k);
            if (kind == 1 || kind == 2) begin
                case (k)
                    1:       check_outs(tag, 1, 32'h341, epc, 0, 0, 0, 1);
                    2:       check_outs(tag, 1, 32'h300, ms_trap, 0, 0, 0, 1);
                    3:       check_outs(tag, 1, 32'h342, cause, 1, target, ack, 0);
                    default: check_outs(tag, 0, 0, 0, 0, 0, 0, 0);
                endcase
            end else if (kind == 3 && k == 1) begin
                check_outs(tag, 1, 32'h300, ms_ret, 1, mepc, 0, 0);
            end else begin
                check_outs(tag, 0, 0, 0, 0, 0, 0, 0);
            end
        end
    endtask

    initial begin
        logic [31:0] r_inst;
        int          sel;

        rst = 1'b1;
        clear_triggers();
        int_en_i = '0; global_int_en_i = 1'b0; inst_addr_i = '0; jump_addr_i = '0;
        csr_mtvec = '0; csr_mepc = '0; csr_mstatus = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Directed cases
        do_trans(0, ECALL, 4'b0000, 4'hF, 1, 0, 0, 0, 32'h100, 32'h200, 32'h8, 0);
        do_trans(1, NOP, 4'b1010, 4'hF, 1, 0, 0, 0, 32'h104, 32'h200, 32'h8, 0);
        do_trans(2, NOP, 4'b1010, 4'b1000, 1, 0, 0, 0, 32'h108, 32'h200, 32'h8, 0);
        do_trans(3, NOP, 4'b0001, 4'hF, 0, 0, 0, 0, 32'h10C, 32'h200, 32'h0, 0);
        do_trans(4, NOP, 4'b0001, 4'hE, 1, 0, 0, 0, 32'h10C, 32'h200, 32'h8, 0);
        do_trans(5, ECALL, 4'b0001, 4'hF, 1, 0, 0, 0, 32'h110, 32'h200, 32'h8, 0);
        do_trans(6, ECALL, 4'b0000, 4'hF, 1, 0, 0, 1, 32'h114, 32'h200, 32'h8, 0);
        do_trans(7, NOP, 4'b0001, 4'hF, 1, 1, 32'h400, 0, 32'h118, 32'h200, 32'h8, 0);
        do_trans(8, MRET, 4'b0000, 4'hF, 0, 0, 0, 0, 32'h11C, 32'h200, 32'h80, 32'h104);
        do_trans(9, NOP, 4'b0100, 4'hF, 1, 0, 0, 0, 32'h120, 32'h201, 32'h8, 0);
        do_trans(10, EBREAK, 4'b0000, 4'h0, 1, 1, 32'h2, 0, 32'h124, 32'h301, 32'h8, 0);
        do_trans(11, NOP, 4'b0010, 4'hF, 1, 0, 0, 1, 32'h0, 32'h201, 32'h8, 0);

        // Reset while the MSTATUS write is pending aborts the sequence
        $display("txn rst inst=%08h reset during MSTATUS", ECALL);
        @(negedge clk);
        inst_i = ECALL; inst_addr_i = 32'h200; csr_mtvec = 32'h300; csr_mstatus = 32'h8;
        @(posedge clk);
        @(negedge clk);
        clear_triggers();
        @(posedge clk);
        @(negedge clk);
        #1;
        check_outs("rst.mepc", 1, 32'h341, 32'h200, 0, 0, 0, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_outs("rst.abort", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check_outs("rst.after", 0, 0, 0, 0, 0, 0, 0);
        end

        // Randomized transactions
        for (int t = 0; t < 200; t++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       r_inst = ECALL;
                1:       r_inst = EBREAK;
                2, 3:    r_inst = MRET;
                4:       r_inst = $urandom();
                default: r_inst = NOP;
            endcase
            do_trans(100 + t, r_inst, 4'($urandom()), 4'($urandom()),
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                     $urandom(), 1'($urandom_range(0, 3) == 0), $urandom(),
                     $urandom(), $urandom(), $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
